rotor_reverse: RTL and testbench
================================

ROTOR_REVERSE -- requirements
Module: rotor_reverse

Interface
REQ-001 Parameter: BASE, default 8'h41, ASCII code of letter index 0 ('A').
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 set  input  1  load configuration from cfg_* this edge.
REQ-005 cfg_pos  input  5  initial rotor position 0..25.
REQ-006 cfg_step  input  5  position increment per step; values 26..31 latched as value-26.
REQ-007 cfg_notch  input  5  turnover position 0..25.
REQ-008 cfg_wiring  input  208  forward table; entry i (ASCII) at bits [207-8i -: 8], i=0..25.
REQ-009 step  input  1  advance position by one increment.
REQ-010 in_valid / in_ready  input / output  1 / 1  return-path character handshake.
REQ-011 in_char  input  8  ASCII character entering the rotor on the return path.
REQ-012 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-013 out_char  output  8  inverse-substituted ASCII letter; 8'h00 on error.
REQ-014 out_err  output  1  in_char not present in wiring table; qualified by out_valid.
REQ-015 carry  output  1  one-cycle turnover pulse to the next rotor.

Function
REQ-016 FSM states: IDLE, SCAN, OUT; in_ready = 1 only in IDLE with set low.
REQ-017 IDLE: in_valid&in_ready captures in_char and a snapshot of pos, clears scan index k to 0, goes to SCAN.
REQ-018 SCAN: each cycle compares wiring[k] with captured char; one entry per cycle, k ascending.
REQ-019 Match at k: out_char <= ((k - pos_snap) mod 26) + BASE, out_err <= 0, go to OUT; out_valid is high k+2 edges after the accepting edge.
REQ-020 No match at k=25: out_char <= 8'h00, out_err <= 1, go to OUT (27 edges after accept).
REQ-021 Duplicate table entries: lowest matching k wins.
REQ-022 OUT: out_valid = 1, out_char/out_err held stable until out_valid&out_ready; then IDLE next edge.
REQ-023 No new input is accepted in the cycle OUT completes; next accept no earlier than the following cycle.
REQ-024 step (any state): pos <= (pos + step_inc) mod 26, 6-bit intermediate, subtract 26 when >=26.
REQ-025 carry = 1 for exactly the cycle after a step whose pre-step pos equals notch; else 0.
REQ-026 step during SCAN/OUT does not affect the in-flight result (pos_snap used).
REQ-027 set: latches wiring, notch, step_inc; pos <= cfg_pos; aborts SCAN/OUT to IDLE with out_valid, out_err dropped.
REQ-028 set and step same edge: set wins, no carry.
REQ-029 Modular subtraction k - pos_snap via 6-bit add of 26; result always 0..25.

Reset
REQ-030 reset_n low: state IDLE, pos 0, step_inc 0, notch 0, wiring 0, k 0.
REQ-031 Reset output values: in_ready 1 (after release), out_valid 0, out_char 8'h00, out_err 0, carry 0.
REQ-032 Reset asserted mid-SCAN/OUT discards the transaction; no out_valid after release.

Structure
REQ-033 Package enigma_pkg holds N_LETTERS=26, ASCII_A=8'h41, FSM state enum, 26x8 wiring array typedef.
REQ-034 One sub-module mod26_addsub (5-bit operands, add/sub select, 5-bit result 0..25), used for step and output offset.

Verification
Wiring "EKMFLGDQVZNTOWYHXUSPAIBCRJ" for all scenarios.
REQ-035 pos 0, in_char 'E' -> out_char 'A', out_err 0, out_valid 2 edges after accept.
REQ-036 pos 0, in_char 'J' -> out_char 'Z' after 27 edges; pos 3, in_char 'E' -> out_char 'X'.
REQ-037 in_char '#' -> out_err 1, out_char 8'h00, 27 edges after accept.
REQ-038 cfg_pos 16, notch 16, step 1, one step pulse -> pos 17, carry high one cycle; second step -> pos 18, no carry; cfg_pos 25 step 1 -> pos 0.
REQ-039 out_ready low 5 cycles in OUT -> out_char stable, in_ready 0; step during OUT leaves out_char unchanged.
REQ-040 set asserted at k=10 of SCAN -> IDLE next edge, no out_valid; reset_n pulse in OUT -> all outputs at reset values.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared types and constants for the rotor datapath.
// Holds the letter count, ASCII base, FSM states and wiring table type.
package enigma_pkg;

    localparam int N_LETTERS = 26;
    localparam logic [7:0] ASCII_A = 8'h41;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        OUT
    } state_t;

    typedef logic [N_LETTERS-1:0][7:0] wiring_t;

endpackage

// File: rtl/mod26_addsub.sv
// Modulo-26 add or subtract of two letter indices (0..25).
// Uses a 6-bit intermediate with a single conditional correction.
module mod26_addsub (
    input  logic [4:0] a,
    input  logic [4:0] b,
    input  logic       sub,
    output logic [4:0] y
);

    logic [5:0] raw;
    logic [5:0] fix;

    always_comb begin
        if (sub) begin
            raw = {1'b0, a} + 6'd26 - {1'b0, b};
        end else begin
            raw = {1'b0, a} + {1'b0, b};
        end
        fix = (raw >= 6'd26) ? raw - 6'd26 : raw;
        y = fix[4:0];
    end

endmodule

// File: rtl/rotor_reverse.sv
// Return-path rotor: inverse substitution by linear table scan.
// Stepping, turnover carry and configuration run alongside the scan.
module rotor_reverse
    import enigma_pkg::*;
#(
    parameter logic [7:0] BASE = ASCII_A
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         set,
    input  logic [4:0]   cfg_pos,
    input  logic [4:0]   cfg_step,
    input  logic [4:0]   cfg_notch,
    input  logic [207:0] cfg_wiring,
    input  logic         step,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_char,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_char,
    output logic         out_err,
    output logic         carry
);

    state_t     state_q;
    state_t     state_d;
    wiring_t    wiring_q;
    wiring_t    cfg_tbl;
    logic [4:0] pos_q;
    logic [4:0] snap_q;
    logic [4:0] step_inc_q;
    logic [4:0] notch_q;
    logic [4:0] k_q;
    logic [7:0] ch_q;
    logic [7:0] out_char_q;
    logic       out_err_q;
    logic       out_valid_q;
    logic       carry_q;
    logic [4:0] pos_step;
    logic [4:0] ofs;
    logic [4:0] step_lat;
    logic       hit;
    logic       accept;

    mod26_addsub u_step (
        .a   (pos_q),
        .b   (step_inc_q),
        .sub (1'b0),
        .y   (pos_step)
    );

    mod26_addsub u_ofs (
        .a   (k_q),
        .b   (snap_q),
        .sub (1'b1),
        .y   (ofs)
    );

    always_comb begin
        cfg_tbl = '0;
        for (int i = 0; i < N_LETTERS; i++) begin
            cfg_tbl[i] = cfg_wiring[207-8*i -: 8];
        end
    end

    assign step_lat  = (cfg_step >= 5'd26) ? cfg_step - 5'd26 : cfg_step;
    assign hit       = (wiring_q[k_q] == ch_q);
    assign in_ready  = (state_q == IDLE) && !set;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;
    assign out_err   = out_err_q;
    assign carry     = carry_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = SCAN;
            SCAN: if (hit || k_q == 5'd25) state_d = OUT;
            OUT:  if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (set) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wiring_q    <= '0;
            pos_q       <= '0;
            snap_q      <= '0;
            step_inc_q  <= '0;
            notch_q     <= '0;
            k_q         <= '0;
            ch_q        <= '0;
            out_char_q  <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= step && !set && (pos_q == notch_q);
            if (set) begin
                wiring_q    <= cfg_tbl;
                notch_q     <= cfg_notch;
                step_inc_q  <= step_lat;
                pos_q       <= cfg_pos;
                out_valid_q <= 1'b0;
                out_err_q   <= 1'b0;
            end else begin
                if (step) pos_q <= pos_step;
                unique case (state_q)
                    IDLE: begin
                        if (accept) begin
                            ch_q   <= in_char;
                            snap_q <= pos_q;
                            k_q    <= '0;
                        end
                    end
                    SCAN: begin
                        if (hit) begin
                            out_char_q <= {3'b000, ofs} + BASE;
                            out_err_q  <= 1'b0;
                        end else if (k_q == 5'd25) begin
                            out_char_q <= 8'h00;
                            out_err_q  <= 1'b1;
                        end else begin
                            k_q <= k_q + 5'd1;
                        end
                    end
                    // result becomes visible one edge after entering OUT
                    OUT: begin
                        if (!out_valid_q) begin
                            out_valid_q <= 1'b1;
                        end else if (out_ready) begin
                            out_valid_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rotor_reverse.sv
// Directed bench for rotor_reverse using the rotor I wiring.
// Each scenario task checks its own results inline.
module tb_rotor_reverse;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         set = 1'b0;
    logic [4:0]   cfg_pos = '0;
    logic [4:0]   cfg_step = '0;
    logic [4:0]   cfg_notch = '0;
    logic [207:0] cfg_wiring = "EKMFLGDQVZNTOWYHXUSPAIBCRJ";
    logic         step = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_char = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [7:0]   out_char;
    logic         out_err;
    logic         carry;

    int tests = 0;
    int fails = 0;

    rotor_reverse dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .set        (set),
        .cfg_pos    (cfg_pos),
        .cfg_step   (cfg_step),
        .cfg_notch  (cfg_notch),
        .cfg_wiring (cfg_wiring),
        .step       (step),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_char   (out_char),
        .out_err    (out_err),
        .carry      (carry)
    );

    always #5 clk = ~clk;

    task automatic do_set(input logic [4:0] p, input logic [4:0] s,
                          input logic [4:0] n, input logic with_step);
        @(negedge clk);
        cfg_pos = p;
        cfg_step = s;
        cfg_notch = n;
        set = 1'b1;
        step = with_step;
        @(negedge clk);
        set = 1'b0;
        step = 1'b0;
    endtask

    // lat = edges from accept to first out_valid; -1 on timeout
    task automatic send(input logic [7:0] ch, input logic rdy,
                        output int lat, output logic [7:0] oc,
                        output logic oe);
        int guard;
        lat = -1;
        oc = 8'hxx;
        oe = 1'bx;
        @(negedge clk);
        out_ready = rdy;
        in_char = ch;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        oc = out_char;
        oe = out_err;
        if (rdy && lat > 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_step(output logic c1, output logic c2);
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        #1 c1 = carry;
        @(negedge clk);
        step = 1'b0;
        @(posedge clk);
        #1 c2 = carry;
    endtask

    task automatic test_reset;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_char !== 8'h00 ||
            out_err !== 1'b0 || carry !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b c=%h e=%b k=%b want 0 00 0 0",
                     out_valid, out_char, out_err, carry);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        int lat;
        logic [7:0] oc;
        logic oe;
        do_set(5'd0, 5'd1, 5'd16, 1'b0);
        send("E", 1'b1, lat, oc, oe);
        tests++;
        if (oc !== "A" || oe !== 1'b0 || lat != 2) begin
            fails++;
            $display("FAIL basic_E: got %h err=%b lat=%0d want 41 0 2",
                     oc, oe, lat);
        end
        send("J", 1'b1, lat, oc, oe);
        tests++;
        if (oc !== "Z" || oe !== 1'b0 || lat != 27) begin
            fails++;
            $display("FAIL basic_J: got %h err=%b lat=%0d want 5a 0 27",
                     oc, oe, lat);
        end
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_idle: got v=%b r=%b want 0 1",
                     out_valid, in_ready);
        end
        do_set(5'd3, 5'd1, 5'd16, 1'b0);
        send("E", 1'b1, lat, oc, oe);
        tests++;
        if (oc !== "X" || lat != 2) begin
            fails++;
            $display("FAIL basic_pos3: got %h lat=%0d want 58 2", oc, lat);
        end
    endtask

    task automatic test_error;
        int lat;
        logic [7:0] oc;
        logic oe;
        send("#", 1'b1, lat, oc, oe);
        tests++;
        if (oc !== 8'h00 || oe !== 1'b1 || lat != 27) begin
            fails++;
            $display("FAIL error_hash: got %h err=%b lat=%0d want 00 1 27",
                     oc, oe, lat);
        end
    endtask

    task automatic test_step;
        int lat;
        logic [7:0] oc;
        logic oe;
        logic c1;
        logic c2;
        do_set(5'd16, 5'd1, 5'd16, 1'b0);
        pulse_step(c1, c2);
        tests++;
        if (c1 !== 1'b1 || c2 !== 1'b0) begin
            fails++;
            $display("FAIL step_carry: got %b%b want 10", c1, c2);
        end
        send("E", 1'b1, lat, oc, oe);
        tests++;
        if (oc !== "J") begin
            fails++;
            $display("FAIL step_pos17: got %h want 4a", oc);
        end
        pulse_step(c1, c2);
        tests++;
        if (c1 !== 1'b0 || c2 !== 1'b0) begin
            fails++;
            $display("FAIL step_nocarry: got %b%b want 00", c1, c2);
        end
        send("E", 1'b1, lat, oc, oe);
        tests++;
        if (oc !== "I") begin
            fails++;
            $display("FAIL step_pos18: got %h want 49", oc);
        end
        do_set(5'd25, 5'd1, 5'd0, 1'b0);
        pulse_step(c1, c2);
        send("E", 1'b1, lat, oc, oe);
        tests++;
        if (oc !== "A" || c1 !== 1'b0) begin
            fails++;
            $display("FAIL step_wrap: got %h carry=%b want 41 0", oc, c1);
        end
        do_set(5'd0, 5'd30, 5'd0, 1'b0);
        pulse_step(c1, c2);
        send("E", 1'b1, lat, oc, oe);
        tests++;
        if (oc !== "W" || c1 !== 1'b1) begin
            fails++;
            $display("FAIL step_inc30: got %h carry=%b want 57 1", oc, c1);
        end
        do_set(5'd16, 5'd1, 5'd16, 1'b1);
        #1;
        tests++;
        if (carry !== 1'b0) begin
            fails++;
            $display("FAIL set_step_carry: got %b want 0", carry);
        end
        send("E", 1'b1, lat, oc, oe);
        tests++;
        if (oc !== "K") begin
            fails++;
            $display("FAIL set_wins: got %h want 4b", oc);
        end
    endtask

    task automatic test_hold;
        int lat;
        logic [7:0] oc;
        logic oe;
        int bad;
        do_set(5'd0, 5'd1, 5'd16, 1'b0);
        send("E", 1'b0, lat, oc, oe);
        tests++;
        if (oc !== "A" || lat != 2) begin
            fails++;
            $display("FAIL hold_first: got %h lat=%0d want 41 2", oc, lat);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            step = (i == 2);
            @(posedge clk);
            #1;
            if (out_char !== "A" || out_valid !== 1'b1 || in_ready !== 1'b0)
                bad++;
        end
        step = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_stable: got %0d bad cycles want 0", bad);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL hold_release: got v=%b want 0", out_valid);
        end
        send("E", 1'b1, lat, oc, oe);
        tests++;
        if (oc !== "Z") begin
            fails++;
            $display("FAIL hold_step_applied: got %h want 5a", oc);
        end
    endtask

    task automatic test_abort;
        int seen;
        do_set(5'd0, 5'd1, 5'd16, 1'b0);
        @(negedge clk);
        in_char = "J";
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        set = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL abort_edge: got v=%b r=%b want 0 0",
                     out_valid, in_ready);
        end
        @(negedge clk);
        set = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL abort_idle: got r=%b want 1", in_ready);
        end
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL abort_no_valid: got %0d want 0", seen);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [7:0] oc;
        logic oe;
        int seen;
        send("E", 1'b0, lat, oc, oe);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_char !== 8'h00 ||
            out_err !== 1'b0 || carry !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: got v=%b c=%h e=%b k=%b want 0 00 0 0",
                     out_valid, out_char, out_err, carry);
        end
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_ready: got %b want 1", in_ready);
        end
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL reset_mid_no_valid: got %0d want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error();
        test_step();
        test_hold();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
